// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// state enum, opcode/funct constants, write-back mux encodings and control bundles.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HALT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_MDWAIT = 3'd6
    } state_t;

    // Opcode field values; the 3-bit classes compare against opcode[5:3].
    localparam logic [5:0] OP_SPECIAL         = 6'b000000;
    localparam logic [5:0] OP_REGIMM          = 6'b000001;
    localparam logic [5:0] OP_JAL             = 6'b000011;
    localparam logic [5:0] OP_BLEZ            = 6'b000110;
    localparam logic [5:0] OP_BGTZ            = 6'b000111;
    localparam logic [2:0] OP_LOAD_CLASS      = 3'b100;
    localparam logic [2:0] OP_STORE_CLASS     = 3'b101;
    localparam logic [2:0] OP_ITYPE_ALU_CLASS = 3'b001;

    localparam logic [5:0] FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [2:0] SEL_ALU  = 3'd0;
    localparam logic [2:0] SEL_MEM  = 3'd1;
    localparam logic [2:0] SEL_LINK = 3'd2;
    localparam logic [2:0] SEL_HI   = 3'd3;
    localparam logic [2:0] SEL_LO   = 3'd4;

    // is_jalr qualifies is_link: JALR writes rd instead of $31.
    typedef struct packed {
        logic is_load;
        logic is_store;
        logic is_link;
        logic is_jalr;
        logic is_muldiv;
        logic is_rtype_alu;
        logic is_itype_alu;
        logic is_mfhi;
        logic is_mflo;
        logic is_mthi;
        logic is_mtlo;
    } instr_class_t;

    typedef struct packed {
        logic       ir_en;
        logic       pc_en;
        logic       mem_read;
        logic       mem_write;
        logic       reg_read_en;
        logic       alu_reg_en;
        logic       reg_write_en;
        logic       hi_en;
        logic       lo_en;
        logic       muldiv_start;
        logic [1:0] reg_write_dst;
        logic [2:0] reg_write_data_sel;
    } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the instruction register/datapath (master) and the
// multicycle control FSM (slave).
interface mc_control_fsm_if;
    logic [31:0] instr;
    logic        waitrequest;
    logic        halt_req;
    logic [2:0]  state;
    logic        active;
    logic        ir_en;
    logic        pc_en;
    logic        mem_read;
    logic        mem_write;
    logic        reg_read_en;
    logic        alu_reg_en;
    logic        reg_write_en;
    logic        hi_en;
    logic        lo_en;
    logic        muldiv_start;
    logic        branch_sel;
    logic [1:0]  reg_write_dst;
    logic [2:0]  reg_write_data_sel;

    modport master (
        output instr, waitrequest, halt_req,
        input  state, active, ir_en, pc_en, mem_read, mem_write, reg_read_en,
               alu_reg_en, reg_write_en, hi_en, lo_en, muldiv_start, branch_sel,
               reg_write_dst, reg_write_data_sel
    );

    modport slave (
        input  instr, waitrequest, halt_req,
        output state, active, ir_en, pc_en, mem_read, mem_write, reg_read_en,
               alu_reg_en, reg_write_en, hi_en, lo_en, muldiv_start, branch_sel,
               reg_write_dst, reg_write_data_sel
    );
endinterface

// File: rtl/mc_control_fsm_instr_class.sv
// Combinational instruction classifier: decodes the instruction word into the
// class flags the control FSM sequences on, plus the branch-compare select.
module mc_instr_class
    import mc_ctrl_pkg::*;
(
    input  logic [31:0]  i_instr,
    output instr_class_t o_class,
    output logic         o_branch_sel
);
    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic [4:0] w_rt;
    logic       w_unused;

    assign w_op     = i_instr[31:26];
    assign w_fn     = i_instr[5:0];
    assign w_rt     = i_instr[20:16];
    assign w_unused = ^{i_instr[25:21], i_instr[15:6]};

    // NOTE: every field gets a value before any branch so no latch can be inferred.
    always_comb begin
        o_class              = '0;
        o_class.is_load      = (w_op[5:3] == OP_LOAD_CLASS);
        o_class.is_store     = (w_op[5:3] == OP_STORE_CLASS);
        o_class.is_itype_alu = (w_op[5:3] == OP_ITYPE_ALU_CLASS);
        if (w_op == OP_SPECIAL) begin
            case (w_fn)
                FN_JALR: begin
                    o_class.is_link = 1'b1;
                    o_class.is_jalr = 1'b1;
                end
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: o_class.is_muldiv = 1'b1;
                FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_SLT, FN_SLTU:
                    o_class.is_rtype_alu = 1'b1;
                FN_MFHI: o_class.is_mfhi = 1'b1;
                FN_MFLO: o_class.is_mflo = 1'b1;
                FN_MTHI: o_class.is_mthi = 1'b1;
                FN_MTLO: o_class.is_mtlo = 1'b1;
                default: o_class.is_rtype_alu = (w_fn[5:3] == 3'b000);
            endcase
        end
        if ((w_op == OP_JAL) ||
            ((w_op == OP_REGIMM) && ((w_rt == RT_BLTZAL) || (w_rt == RT_BGEZAL))))
            o_class.is_link = 1'b1;
    end

    assign o_branch_sel = (w_op == OP_REGIMM) || (w_op == OP_BLEZ) || (w_op == OP_BGTZ);

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: owns the instruction-cycle state, sequences
// variable-length instructions, memory stalls, mul/div waits and halt.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter bit SKIP_MEM      = 1'b1
)(
    input logic             clk,
    input logic             reset,
    mc_control_fsm_if.slave bus
);
    localparam logic [4:0] MD_LOAD = 5'(MULDIV_CYCLES - 1);

    instr_class_t w_cls;
    logic         w_branch_sel;
    state_t       r_state;
    state_t       w_next_state;
    logic [4:0]   r_md_cnt;
    logic         w_md_load;
    logic         w_md_dec;
    ctrl_t        w_ctrl;
    logic         w_active;
    logic         w_mem_access;

    mc_instr_class u_instr_class (
        .i_instr      (bus.instr),
        .o_class      (w_cls),
        .o_branch_sel (w_branch_sel)
    );

    assign w_mem_access = w_cls.is_load | w_cls.is_store;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_FETCH;
            r_md_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_md_load)
                r_md_cnt <= MD_LOAD;
            else if (w_md_dec)
                r_md_cnt <= r_md_cnt - 5'd1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ctrl       = '0;
        w_active     = 1'b1;
        w_md_load    = 1'b0;
        w_md_dec     = 1'b0;
        case (r_state)
            ST_HALT: w_active = 1'b0;
            ST_FETCH: begin
                if (bus.halt_req) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_ctrl.mem_read = 1'b1;
                    if (!bus.waitrequest) begin
                        w_ctrl.ir_en = 1'b1;
                        w_next_state = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                w_ctrl.reg_read_en = 1'b1;
                w_next_state       = ST_EXEC;
            end
            ST_EXEC: begin
                w_ctrl.alu_reg_en = 1'b1;
                if (w_cls.is_muldiv) begin
                    w_ctrl.muldiv_start = 1'b1;
                    w_md_load           = 1'b1;
                    w_next_state        = ST_MDWAIT;
                end else if (w_mem_access || w_cls.is_link) begin
                    w_next_state = ST_MEM;
                end else begin
                    w_next_state = SKIP_MEM ? ST_WB : ST_MEM;
                end
            end
            ST_MDWAIT: begin
                if (r_md_cnt == '0)
                    w_next_state = ST_WB;
                else
                    w_md_dec = 1'b1;
            end
            ST_MEM: begin
                w_ctrl.mem_read  = w_cls.is_load;
                w_ctrl.mem_write = w_cls.is_store;
                if (w_cls.is_link) begin
                    w_ctrl.reg_write_en       = 1'b1;
                    w_ctrl.reg_write_data_sel = SEL_LINK;
                    w_ctrl.reg_write_dst      = w_cls.is_jalr ? DST_RD : DST_RA;
                end
                if (!(w_mem_access && bus.waitrequest))
                    w_next_state = ST_WB;
            end
            ST_WB: begin
                w_ctrl.pc_en = 1'b1;
                w_next_state = ST_FETCH;
                if (w_cls.is_load) begin
                    w_ctrl.reg_write_en       = 1'b1;
                    w_ctrl.reg_write_data_sel = SEL_MEM;
                    w_ctrl.reg_write_dst      = DST_RT;
                end else if (w_cls.is_rtype_alu || w_cls.is_mfhi || w_cls.is_mflo) begin
                    w_ctrl.reg_write_en       = 1'b1;
                    w_ctrl.reg_write_dst      = DST_RD;
                    w_ctrl.reg_write_data_sel = w_cls.is_mfhi ? SEL_HI :
                                                w_cls.is_mflo ? SEL_LO : SEL_ALU;
                end else if (w_cls.is_itype_alu) begin
                    w_ctrl.reg_write_en       = 1'b1;
                    w_ctrl.reg_write_data_sel = SEL_ALU;
                    w_ctrl.reg_write_dst      = DST_RT;
                end else begin
                    w_ctrl.hi_en = w_cls.is_muldiv | w_cls.is_mthi;
                    w_ctrl.lo_en = w_cls.is_muldiv | w_cls.is_mtlo;
                end
            end
            default: w_next_state = ST_FETCH;
        endcase
        // Reset silences the datapath even while the state register still holds its old value.
        if (reset) begin
            w_ctrl   = '0;
            w_active = 1'b1;
        end
    end

    assign bus.state              = r_state;
    assign bus.active             = w_active;
    assign bus.ir_en              = w_ctrl.ir_en;
    assign bus.pc_en              = w_ctrl.pc_en;
    assign bus.mem_read           = w_ctrl.mem_read;
    assign bus.mem_write          = w_ctrl.mem_write;
    assign bus.reg_read_en        = w_ctrl.reg_read_en;
    assign bus.alu_reg_en         = w_ctrl.alu_reg_en;
    assign bus.reg_write_en       = w_ctrl.reg_write_en;
    assign bus.hi_en              = w_ctrl.hi_en;
    assign bus.lo_en              = w_ctrl.lo_en;
    assign bus.muldiv_start       = w_ctrl.muldiv_start;
    assign bus.branch_sel         = w_branch_sel;
    assign bus.reg_write_dst      = w_ctrl.reg_write_dst;
    assign bus.reg_write_data_sel = w_ctrl.reg_write_data_sel;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-instruction cycle traces are built
// from the timing rules and compared cycle by cycle against the DUT outputs.
module tb_mc_control_fsm;
    localparam int MDC  = 4;
    localparam bit SKIP = 1'b1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_control_fsm_if bus ();

    mc_control_fsm #(.MULDIV_CYCLES(MDC), .SKIP_MEM(SKIP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {
        K_LOAD, K_STORE, K_JAL, K_JALR, K_LINKBR, K_MULDIV, K_RALU,
        K_IALU, K_MFHI, K_MFLO, K_MTHI, K_MTLO, K_OTHER, K_NUM
    } kind_t;

    typedef struct packed {
        logic [2:0] st;
        logic       active, ir_en, pc_en, mem_read, mem_write, reg_read_en;
        logic       alu_reg_en, reg_write_en, hi_en, lo_en, muldiv_start, branch_sel;
        logic [1:0] dst;
        logic [2:0] sel;
    } obs_t;

    typedef struct {
        obs_t e;
        logic wr;
        logic halt;
    } step_t;

    step_t       tq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    string       cur_tag;
    logic [31:0] cur_instr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.st           = bus.state;
        o.active       = bus.active;
        o.ir_en        = bus.ir_en;
        o.pc_en        = bus.pc_en;
        o.mem_read     = bus.mem_read;
        o.mem_write    = bus.mem_write;
        o.reg_read_en  = bus.reg_read_en;
        o.alu_reg_en   = bus.alu_reg_en;
        o.reg_write_en = bus.reg_write_en;
        o.hi_en        = bus.hi_en;
        o.lo_en        = bus.lo_en;
        o.muldiv_start = bus.muldiv_start;
        o.branch_sel   = bus.branch_sel;
        o.dst          = bus.reg_write_dst;
        o.sel          = bus.reg_write_data_sel;
        return o;
    endfunction

    function automatic logic is_branch(input logic [31:0] ins);
        return (ins[31:26] == 6'd1) || (ins[31:26] == 6'd6) || (ins[31:26] == 6'd7);
    endfunction

    function automatic obs_t idle(input logic [2:0] st, input logic br);
        obs_t o = '0;
        o.st         = st;
        o.active     = 1'b1;
        o.branch_sel = br;
        return o;
    endfunction

    // Random encoding of a given instruction kind; unconstrained fields stay random.
    function automatic logic [31:0] make_instr(input kind_t k);
        logic [31:0] r = $urandom;
        case (k)
            K_LOAD:   r[31:29] = 3'b100;
            K_STORE:  r[31:29] = 3'b101;
            K_IALU:   r[31:29] = 3'b001;
            K_JAL:    r[31:26] = 6'b000011;
            K_JALR:   begin r[31:26] = 6'd0; r[5:0] = 6'b001001; end
            K_LINKBR: begin r[31:26] = 6'd1; r[20:17] = 4'b1000; end
            K_MULDIV: begin r[31:26] = 6'd0; r[5:2] = 4'b0110; end
            K_MFHI:   begin r[31:26] = 6'd0; r[5:0] = 6'b010000; end
            K_MTHI:   begin r[31:26] = 6'd0; r[5:0] = 6'b010001; end
            K_MFLO:   begin r[31:26] = 6'd0; r[5:0] = 6'b010010; end
            K_MTLO:   begin r[31:26] = 6'd0; r[5:0] = 6'b010011; end
            K_RALU: begin
                r[31:26] = 6'd0;
                case ($urandom_range(0, 7))
                    0: r[5:0] = 6'h21;
                    1: r[5:0] = 6'h23;
                    2: r[5:0] = 6'h24;
                    3: r[5:0] = 6'h25;
                    4: r[5:0] = 6'h26;
                    5: r[5:0] = 6'h2a;
                    6: r[5:0] = 6'h2b;
                    default: r[5:3] = 3'b000;
                endcase
            end
            default: begin
                case ($urandom_range(0, 5))
                    0: begin r[31:26] = 6'd0; r[5:0] = 6'b001000; end
                    1: r[31:26] = 6'b000100;
                    2: r[31:26] = 6'b000010;
                    3: r[31:26] = 6'b000110;
                    4: r[31:26] = 6'b000111;
                    default: begin r[31:26] = 6'd1; r[20:17] = 4'b0000; end
                endcase
            end
        endcase
        return r;
    endfunction

    task automatic push(input obs_t e, input logic wr);
        step_t s;
        s.e    = e;
        s.wr   = wr;
        s.halt = 1'b0;
        tq.push_back(s);
    endtask

    // Expected trace: f fetch stalls, m memory stalls on loads/stores.
    task automatic build(input kind_t k, input logic [31:0] ins, input int f, input int m);
        obs_t e;
        logic br = is_branch(ins);
        for (int i = 0; i <= f; i++) begin
            e = idle(3'd1, br); e.mem_read = 1'b1; e.ir_en = (i == f);
            push(e, i < f);
        end
        e = idle(3'd2, br); e.reg_read_en = 1'b1; push(e, 1'($urandom));
        e = idle(3'd3, br); e.alu_reg_en = 1'b1; e.muldiv_start = (k == K_MULDIV);
        push(e, 1'($urandom));
        if (k == K_MULDIV) begin
            for (int i = 0; i < MDC; i++) push(idle(3'd6, br), 1'($urandom));
        end else if (k == K_LOAD || k == K_STORE) begin
            for (int i = 0; i <= m; i++) begin
                e = idle(3'd4, br); e.mem_read = (k == K_LOAD); e.mem_write = (k == K_STORE);
                push(e, i < m);
            end
        end else if (k inside {K_JAL, K_JALR, K_LINKBR}) begin
            e = idle(3'd4, br); e.reg_write_en = 1'b1; e.sel = 3'd2;
            e.dst = (k == K_JALR) ? 2'd1 : 2'd2;
            push(e, 1'($urandom));
        end else if (!SKIP) begin
            push(idle(3'd4, br), 1'($urandom));
        end
        e = idle(3'd5, br); e.pc_en = 1'b1;
        case (k)
            K_LOAD:   begin e.reg_write_en = 1'b1; e.sel = 3'd1; e.dst = 2'd0; end
            K_RALU:   begin e.reg_write_en = 1'b1; e.sel = 3'd0; e.dst = 2'd1; end
            K_IALU:   begin e.reg_write_en = 1'b1; e.sel = 3'd0; e.dst = 2'd0; end
            K_MFHI:   begin e.reg_write_en = 1'b1; e.sel = 3'd3; e.dst = 2'd1; end
            K_MFLO:   begin e.reg_write_en = 1'b1; e.sel = 3'd4; e.dst = 2'd1; end
            K_MULDIV: begin e.hi_en = 1'b1; e.lo_en = 1'b1; end
            K_MTHI:   e.hi_en = 1'b1;
            K_MTLO:   e.lo_en = 1'b1;
            default:  ;
        endcase
        push(e, 1'($urandom));
    endtask

    // Plays up to n queued cycles (n < 0: all), then discards the remainder.
    task automatic play(input int n);
        step_t s;
        int    c = 0;
        while (tq.size() > 0 && (n < 0 || c < n)) begin
            s = tq.pop_front();
            bus.instr       = cur_instr;
            bus.waitrequest = s.wr;
            bus.halt_req    = s.halt;
            @(negedge clk);
            check($sformatf("%s_c%0d", cur_tag, c), 32'(sample()), 32'(s.e));
            @(posedge clk);
            #1;
            c++;
        end
        tq.delete();
    endtask

    task automatic run(input string tag, input kind_t k, input logic [31:0] ins,
                       input int f, input int m);
        cur_tag   = tag;
        cur_instr = ins;
        build(k, ins, f, m);
        play(-1);
    endtask

    task automatic reset_cycle(input string tag, input logic [2:0] st_during);
        reset = 1'b1;
        bus.waitrequest = 1'($urandom);
        bus.halt_req    = 1'($urandom);
        @(negedge clk);
        check(tag, 32'(sample()), 32'(idle(st_during, is_branch(bus.instr))));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        kind_t k;
        obs_t  e;
        step_t s;
        reset           = 1'b1;
        bus.instr       = 32'd0;
        bus.waitrequest = 1'b1;
        bus.halt_req    = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            bus.halt_req = (i == 1);
            @(negedge clk);
            check($sformatf("reset_c%0d", i), 32'(sample()), 32'(idle(3'd1, 1'b0)));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        run("addu_fstall", K_RALU, {6'd0, 15'($urandom), 5'd0, 6'h21}, 3, 0);
        run("lw_mstall",   K_LOAD, {6'b100011, 26'($urandom)}, 0, 2);
        run("divu",        K_MULDIV, {6'd0, 20'($urandom), 6'b011011}, 0, 0);
        run("jalr",        K_JALR, {6'd0, 20'($urandom), 6'b001001}, 0, 0);
        run("bgezal",      K_LINKBR, {6'd1, 5'($urandom), 5'b10001, 16'($urandom)}, 0, 0);
        run("sw_both",     K_STORE, {6'b101011, 26'($urandom)}, 1, 3);

        for (int i = 0; i < 150; i++) begin
            k = kind_t'($urandom_range(0, int'(K_NUM) - 1));
            run($sformatf("rnd%0d_k%0d", i, int'(k)), k, make_instr(k),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
        end

        // Reset while waiting on a MULT: the HI/LO write must never happen.
        cur_tag   = "mult_abort";
        cur_instr = {6'd0, 20'($urandom), 6'b011000};
        build(K_MULDIV, cur_instr, 0, 0);
        play(5);
        reset_cycle("reset_in_mdwait", 3'd6);
        run("after_abort", K_IALU, make_instr(K_IALU), 0, 0);

        // Halt from FETCH, then stay put regardless of inputs until reset.
        cur_tag   = "halt";
        cur_instr = make_instr(K_OTHER);
        s.e = idle(3'd1, is_branch(cur_instr)); s.wr = 1'($urandom); s.halt = 1'b1;
        tq.push_back(s);
        for (int i = 0; i < 10; i++) begin
            e = idle(3'd0, is_branch(cur_instr)); e.active = 1'b0;
            s.e = e; s.wr = 1'($urandom); s.halt = 1'($urandom);
            tq.push_back(s);
        end
        play(-1);
        reset_cycle("reset_in_halt", 3'd0);
        run("after_halt", K_RALU, make_instr(K_RALU), 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
